// File: rtl/nexi_bus_pkg.sv
// nexi_bus_pkg
// Shared definitions for the two-cache shared-bus arbiter.
//   state_t   : arbiter FSM states. The encodings are chosen to equal the
//               one-hot grant value of each state, so the grant output is
//               the state register itself.
//   GRANT_*   : grant_o encodings (none / cache 0 / cache 1).
//   grant_of  : maps a state onto its grant_o value.
package nexi_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M0   = 2'b01;
   localparam logic [1:0] GRANT_M1   = 2'b10;

   function automatic logic [1:0] grant_of(input state_t s);
      logic [1:0] g;
      g = GRANT_NONE;
      case (s)
         OWN0:    g = GRANT_M0;
         OWN1:    g = GRANT_M1;
         default: g = GRANT_NONE;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/nexi_bus_timeout.sv
// nexi_bus_timeout
// Counts strobe cycles that have not yet been terminated and flags when the
// count reaches TIMEOUT. TIMEOUT = 0 disables the flag entirely.
// Ports:
//   clk_i    : clock, rising edge
//   reset_i  : synchronous active-high reset
//   count_en : one more unterminated strobe cycle this clock
//   clear    : restart counting from zero (dominates count_en)
//   expired  : counter currently equals TIMEOUT
module nexi_bus_timeout
   import nexi_bus_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic count_en,
   input  logic clear,
   output logic expired
);

   // A zero-width counter is not legal, so the disabled case keeps one bit.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] count;

   // The counter saturates at LIMIT so it can never wrap back to zero and
   // hide an expiry if the owner forgets to clear it.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en && (count != LIMIT)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/nexi_bus_arbiter.sv
// nexi_bus_arbiter
// Two-master Wishbone arbiter in front of one shared bus. Whichever cache owns
// the bus is wired straight through in both directions; the other cache sees
// all zeros and its request simply waits. Ties from IDLE alternate between the
// caches, and a strobe left unterminated for TIMEOUT cycles is given a
// synthetic error.
// Ports:
//   clk_i, reset_i                 : clock, synchronous active-high reset
//   m{0,1}_addr_i/_data_i          : cache address / write data
//   m{0,1}_cyc_i/_stb_i/_sel_i/_we_i : cache Wishbone control
//   m{0,1}_data_o                  : read data to cache
//   m{0,1}_ack_o/_err_o/_rty_o     : terminations to cache
//   bus_addr_o/bus_data_o          : shared-bus address / write data
//   bus_cyc_o/_stb_o/_sel_o/_we_o  : shared-bus control
//   bus_data_i                     : shared-bus read data
//   bus_ack_i/_err_i/_rty_i        : shared-bus terminations
//   grant_o                        : one-hot owner (01 cache 0, 10 cache 1)
//   timeout_o                      : one-cycle pulse on a synthetic error
module nexi_bus_arbiter
   import nexi_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [ADDR_WIDTH-1:0] m0_addr_i,
   input  logic [DATA_WIDTH-1:0] m0_data_i,
   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   input  logic                  m0_sel_i,
   input  logic                  m0_we_i,
   output logic [DATA_WIDTH-1:0] m0_data_o,
   output logic                  m0_ack_o,
   output logic                  m0_err_o,
   output logic                  m0_rty_o,
   input  logic [ADDR_WIDTH-1:0] m1_addr_i,
   input  logic [DATA_WIDTH-1:0] m1_data_i,
   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   input  logic                  m1_sel_i,
   input  logic                  m1_we_i,
   output logic [DATA_WIDTH-1:0] m1_data_o,
   output logic                  m1_ack_o,
   output logic                  m1_err_o,
   output logic                  m1_rty_o,
   output logic [ADDR_WIDTH-1:0] bus_addr_o,
   output logic [DATA_WIDTH-1:0] bus_data_o,
   output logic                  bus_cyc_o,
   output logic                  bus_stb_o,
   output logic                  bus_sel_o,
   output logic                  bus_we_o,
   input  logic [DATA_WIDTH-1:0] bus_data_i,
   input  logic                  bus_ack_i,
   input  logic                  bus_err_i,
   input  logic                  bus_rty_i,
   output logic [1:0]            grant_o,
   output logic                  timeout_o
);

   state_t state;
   state_t state_next;
   logic   last_r;
   logic   owner_stb;
   logic   active_stb;
   logic   bus_term;
   logic   expired;
   logic   synth_err;
   logic   count_en;
   logic   count_clear;

   // State register. last_r remembers who was served most recently so a
   // simultaneous request from IDLE goes to the other cache; it starts at 1
   // so cache 0 wins the first tie after reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state  <= IDLE;
         last_r <= 1'b1;
      end else begin
         state <= state_next;
         if ((state_next == OWN0) && (state != OWN0)) begin
            last_r <= 1'b0;
         end else if ((state_next == OWN1) && (state != OWN1)) begin
            last_r <= 1'b1;
         end
      end
   end

   // Next-state logic. Ownership is only released when the owner drops cyc,
   // which keeps multi-beat and read-modify-write cycles atomic. On release
   // the bus is handed straight to a waiting cache without an IDLE cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_next = last_r ? OWN0 : OWN1;
            end else if (m0_cyc_i) begin
               state_next = OWN0;
            end else if (m1_cyc_i) begin
               state_next = OWN1;
            end
         end
         OWN0: begin
            if (!m0_cyc_i) begin
               state_next = m1_cyc_i ? OWN1 : IDLE;
            end
         end
         OWN1: begin
            if (!m1_cyc_i) begin
               state_next = m0_cyc_i ? OWN0 : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Timeout bookkeeping. A real termination always beats the synthetic
   // error in the same cycle. Reset masks the strobe, which also clears the
   // counter.
   assign bus_term   = bus_ack_i | bus_err_i | bus_rty_i;
   assign owner_stb  = (state == OWN0) ? m0_stb_i :
                       (state == OWN1) ? m1_stb_i : 1'b0;
   assign active_stb = owner_stb && !reset_i;
   assign count_en   = active_stb && !bus_term;
   assign synth_err  = expired && active_stb && !bus_term;
   assign count_clear = bus_term || (state_next != state) || !active_stb || synth_err;

   nexi_bus_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .count_en (count_en),
      .clear    (count_clear),
      .expired  (expired)
   );

   // Datapath steering. Everything defaults to zero so IDLE and the
   // non-owning cache see a quiet bus. During reset cyc/stb and every
   // termination are masked so an aborted cycle never completes.
   always_comb begin
      bus_addr_o = '0;
      bus_data_o = '0;
      bus_cyc_o  = 1'b0;
      bus_stb_o  = 1'b0;
      bus_sel_o  = 1'b0;
      bus_we_o   = 1'b0;
      m0_data_o  = '0;
      m0_ack_o   = 1'b0;
      m0_err_o   = 1'b0;
      m0_rty_o   = 1'b0;
      m1_data_o  = '0;
      m1_ack_o   = 1'b0;
      m1_err_o   = 1'b0;
      m1_rty_o   = 1'b0;
      case (state)
         OWN0: begin
            bus_addr_o = m0_addr_i;
            bus_data_o = m0_data_i;
            bus_cyc_o  = m0_cyc_i && !reset_i;
            bus_stb_o  = m0_stb_i && !reset_i;
            bus_sel_o  = m0_sel_i;
            bus_we_o   = m0_we_i;
            m0_data_o  = bus_data_i;
            m0_ack_o   = bus_ack_i && !reset_i;
            m0_err_o   = (bus_err_i || synth_err) && !reset_i;
            m0_rty_o   = bus_rty_i && !reset_i;
         end
         OWN1: begin
            bus_addr_o = m1_addr_i;
            bus_data_o = m1_data_i;
            bus_cyc_o  = m1_cyc_i && !reset_i;
            bus_stb_o  = m1_stb_i && !reset_i;
            bus_sel_o  = m1_sel_i;
            bus_we_o   = m1_we_i;
            m1_data_o  = bus_data_i;
            m1_ack_o   = bus_ack_i && !reset_i;
            m1_err_o   = (bus_err_i || synth_err) && !reset_i;
            m1_rty_o   = bus_rty_i && !reset_i;
         end
         default: begin
         end
      endcase
   end

   assign grant_o   = grant_of(state);
   assign timeout_o = synth_err;

endmodule

// File: tb/tb_nexi_bus_arbiter.sv
// tb_nexi_bus_arbiter
// Drives a table of per-cycle stimulus rows into nexi_bus_arbiter (TIMEOUT=4)
// and compares every output against expectations queued when each row is
// driven and popped on the following falling edge.
module tb_nexi_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk;
   logic          reset_i;
   logic [AW-1:0] m0_addr_i, m1_addr_i, bus_addr_o;
   logic [DW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o;
   logic [DW-1:0] bus_data_o, bus_data_i;
   logic          m0_cyc_i, m0_stb_i, m0_sel_i, m0_we_i;
   logic          m1_cyc_i, m1_stb_i, m1_sel_i, m1_we_i;
   logic          m0_ack_o, m0_err_o, m0_rty_o;
   logic          m1_ack_o, m1_err_o, m1_rty_o;
   logic          bus_cyc_o, bus_stb_o, bus_sel_o, bus_we_o;
   logic          bus_ack_i, bus_err_i, bus_rty_i;
   logic [1:0]    grant_o;
   logic          timeout_o;

   nexi_bus_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (4)
   ) dut (
      .clk_i      (clk),
      .reset_i    (reset_i),
      .m0_addr_i  (m0_addr_i),
      .m0_data_i  (m0_data_i),
      .m0_cyc_i   (m0_cyc_i),
      .m0_stb_i   (m0_stb_i),
      .m0_sel_i   (m0_sel_i),
      .m0_we_i    (m0_we_i),
      .m0_data_o  (m0_data_o),
      .m0_ack_o   (m0_ack_o),
      .m0_err_o   (m0_err_o),
      .m0_rty_o   (m0_rty_o),
      .m1_addr_i  (m1_addr_i),
      .m1_data_i  (m1_data_i),
      .m1_cyc_i   (m1_cyc_i),
      .m1_stb_i   (m1_stb_i),
      .m1_sel_i   (m1_sel_i),
      .m1_we_i    (m1_we_i),
      .m1_data_o  (m1_data_o),
      .m1_ack_o   (m1_ack_o),
      .m1_err_o   (m1_err_o),
      .m1_rty_o   (m1_rty_o),
      .bus_addr_o (bus_addr_o),
      .bus_data_o (bus_data_o),
      .bus_cyc_o  (bus_cyc_o),
      .bus_stb_o  (bus_stb_o),
      .bus_sel_o  (bus_sel_o),
      .bus_we_o   (bus_we_o),
      .bus_data_i (bus_data_i),
      .bus_ack_i  (bus_ack_i),
      .bus_err_i  (bus_err_i),
      .bus_rty_i  (bus_rty_i),
      .grant_o    (grant_o),
      .timeout_o  (timeout_o)
   );

   // One stimulus row = one clock cycle of inputs plus the hand-derived
   // control outputs expected during that same cycle.
   typedef struct {
      logic       rst, c0, s0, c1, s1, ack, err, rty;
      logic [1:0] g;
      logic       bc, bs;
      logic [2:0] r0, r1;
      logic       tmo;
   } vec_t;

   // Full expected output set for one cycle, queued by the driver.
   typedef struct {
      logic [1:0]    g;
      logic [3:0]    ctrl;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata, d0, d1;
      logic [2:0]    r0, r1;
      logic          tmo;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_check = 0;
   int   n_pass  = 0;
   int   row_idx = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic addRow(input logic rst, c0, s0, c1, s1, ack, err, rty,
                         input logic [1:0] g, input logic bc, bs,
                         input logic [2:0] r0, r1, input logic tmo);
      vec_t v;
      v.rst = rst; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1;
      v.ack = ack; v.err = err; v.rty = rty;
      v.g = g; v.bc = bc; v.bs = bs; v.r0 = r0; v.r1 = r1; v.tmo = tmo;
      vecs.push_back(v);
   endtask

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
      n_check++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s row %0d: got %h, expected %h", name, row_idx, act, req);
      end
   endtask

   // Drive one row just after the rising edge, with fresh random payloads,
   // and queue the outputs the row should produce.
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      @(posedge clk);
      #1;
      reset_i   = v.rst;
      m0_cyc_i  = v.c0;  m0_stb_i = v.s0;
      m1_cyc_i  = v.c1;  m1_stb_i = v.s1;
      bus_ack_i = v.ack; bus_err_i = v.err; bus_rty_i = v.rty;
      m0_addr_i = $urandom; m0_data_i = $urandom;
      m1_addr_i = $urandom; m1_data_i = $urandom;
      bus_data_i = $urandom;
      m0_sel_i = 1'($urandom_range(0, 1)); m0_we_i = 1'($urandom_range(0, 1));
      m1_sel_i = 1'($urandom_range(0, 1)); m1_we_i = 1'($urandom_range(0, 1));
      e.g = v.g; e.r0 = v.r0; e.r1 = v.r1; e.tmo = v.tmo;
      e.ctrl = {v.bc, v.bs, 2'b00}; e.addr = '0; e.wdata = '0; e.d0 = '0; e.d1 = '0;
      if (v.g == 2'b01) begin
         e.ctrl[1:0] = {m0_sel_i, m0_we_i};
         e.addr = m0_addr_i; e.wdata = m0_data_i; e.d0 = bus_data_i;
      end else if (v.g == 2'b10) begin
         e.ctrl[1:0] = {m1_sel_i, m1_we_i};
         e.addr = m1_addr_i; e.wdata = m1_data_i; e.d1 = bus_data_i;
      end
      sb.push_back(e);
   endtask

   // Compare all outputs mid-cycle against the oldest queued expectation.
   task automatic checkOutput();
      exp_t e;
      e = sb.pop_front();
      row_idx++;
      checkField("grant",    32'(grant_o), 32'(e.g));
      checkField("bus_ctrl", 32'({bus_cyc_o, bus_stb_o, bus_sel_o, bus_we_o}), 32'(e.ctrl));
      checkField("bus_addr", bus_addr_o, e.addr);
      checkField("bus_wdata", bus_data_o, e.wdata);
      checkField("m0_term",  32'({m0_ack_o, m0_err_o, m0_rty_o}), 32'(e.r0));
      checkField("m1_term",  32'({m1_ack_o, m1_err_o, m1_rty_o}), 32'(e.r1));
      checkField("m0_rdata", m0_data_o, e.d0);
      checkField("m1_rdata", m1_data_o, e.d1);
      checkField("timeout",  32'(timeout_o), 32'(e.tmo));
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) checkOutput();
   end

   initial begin
      $display("[TB] nexi_bus_arbiter test starting");
      reset_i = 1'b1;
      m0_addr_i = '0; m0_data_i = '0; m0_cyc_i = 0; m0_stb_i = 0; m0_sel_i = 0; m0_we_i = 0;
      m1_addr_i = '0; m1_data_i = '0; m1_cyc_i = 0; m1_stb_i = 0; m1_sel_i = 0; m1_we_i = 0;
      bus_data_i = '0; bus_ack_i = 0; bus_err_i = 0; bus_rty_i = 0;

      // Reset state, ack ignored in IDLE, m0 alone with err then ack.
      addRow(1,0,0,0,0,0,0,0, 2'b00,0,0,3'b000,3'b000,0);
      addRow(0,1,1,0,0,1,0,0, 2'b00,0,0,3'b000,3'b000,0);
      addRow(0,1,1,0,0,0,0,0, 2'b01,1,1,3'b000,3'b000,0);
      addRow(0,1,1,0,0,0,1,0, 2'b01,1,1,3'b010,3'b000,0);
      addRow(0,1,1,0,0,1,0,0, 2'b01,1,1,3'b100,3'b000,0);
      addRow(0,0,0,0,0,0,0,0, 2'b01,0,0,3'b000,3'b000,0);
      addRow(0,0,0,0,0,0,0,0, 2'b00,0,0,3'b000,3'b000,0);
      // Tie after reset: m0 first, then direct handover to m1.
      addRow(1,0,0,0,0,0,0,0, 2'b00,0,0,3'b000,3'b000,0);
      addRow(0,1,1,1,1,0,0,0, 2'b00,0,0,3'b000,3'b000,0);
      addRow(0,1,1,1,1,1,0,0, 2'b01,1,1,3'b100,3'b000,0);
      addRow(0,0,0,1,1,0,0,0, 2'b01,0,0,3'b000,3'b000,0);
      addRow(0,0,0,1,1,1,0,0, 2'b10,1,1,3'b000,3'b100,0);
      addRow(0,0,0,0,0,0,0,0, 2'b10,0,0,3'b000,3'b000,0);
      addRow(0,0,0,0,0,0,0,0, 2'b00,0,0,3'b000,3'b000,0);
      // Second tie: m0 wins again; m1 then holds 10 beats while m0 waits.
      addRow(0,1,1,1,1,0,0,0, 2'b00,0,0,3'b000,3'b000,0);
      addRow(0,1,1,1,1,1,0,0, 2'b01,1,1,3'b100,3'b000,0);
      addRow(0,0,0,1,1,0,0,0, 2'b01,0,0,3'b000,3'b000,0);
      for (int i = 0; i < 10; i++) addRow(0,1,1,1,1,1,0,0, 2'b10,1,1,3'b000,3'b100,0);
      addRow(0,1,1,0,0,0,0,0, 2'b10,0,0,3'b000,3'b000,0);
      addRow(0,0,0,0,0,0,0,0, 2'b01,0,0,3'b000,3'b000,0);
      addRow(0,0,0,0,0,0,0,0, 2'b00,0,0,3'b000,3'b000,0);
      // Timeout: err on every 5th unterminated strobe cycle.
      addRow(0,0,0,1,1,0,0,0, 2'b00,0,0,3'b000,3'b000,0);
      for (int i = 0; i < 4; i++) addRow(0,0,0,1,1,0,0,0, 2'b10,1,1,3'b000,3'b000,0);
      addRow(0,0,0,1,1,0,0,0, 2'b10,1,1,3'b000,3'b010,1);
      for (int i = 0; i < 4; i++) addRow(0,0,0,1,1,0,0,0, 2'b10,1,1,3'b000,3'b000,0);
      addRow(0,0,0,1,1,0,0,0, 2'b10,1,1,3'b000,3'b010,1);
      // Ack in the timeout cycle wins.
      for (int i = 0; i < 4; i++) addRow(0,0,0,1,1,0,0,0, 2'b10,1,1,3'b000,3'b000,0);
      addRow(0,0,0,1,1,1,0,0, 2'b10,1,1,3'b000,3'b100,0);
      // A strobe gap restarts the count.
      for (int i = 0; i < 3; i++) addRow(0,0,0,1,1,0,0,0, 2'b10,1,1,3'b000,3'b000,0);
      addRow(0,0,0,1,0,0,0,0, 2'b10,1,0,3'b000,3'b000,0);
      for (int i = 0; i < 4; i++) addRow(0,0,0,1,1,0,0,0, 2'b10,1,1,3'b000,3'b000,0);
      addRow(0,0,0,1,1,0,0,0, 2'b10,1,1,3'b000,3'b010,1);
      addRow(0,0,0,0,0,0,0,0, 2'b10,0,0,3'b000,3'b000,0);
      addRow(0,0,0,0,0,0,0,0, 2'b00,0,0,3'b000,3'b000,0);
      // rty pass-through, then reset mid-cycle with an ack that must not reach m0.
      addRow(0,1,1,0,0,0,0,0, 2'b00,0,0,3'b000,3'b000,0);
      addRow(0,1,1,0,0,0,0,1, 2'b01,1,1,3'b001,3'b000,0);
      addRow(1,1,1,0,0,1,0,0, 2'b01,0,0,3'b000,3'b000,0);
      addRow(0,0,0,0,0,0,0,0, 2'b00,0,0,3'b000,3'b000,0);

      repeat (2) @(posedge clk);
      foreach (vecs[i]) applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkField("sb_drain", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end

endmodule

// File: doc/nexi_bus_arbiter.md
NEXI_BUS_ARBITER -- requirements
Module: nexi_bus_arbiter

Interface
REQ-001 ADDR_WIDTH, 32, address width of all ports.
REQ-002 DATA_WIDTH, 32, data width of all ports.
REQ-003 TIMEOUT, 255, maximum unterminated strobe cycles before a synthetic error; 0 disables the timeout.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_i  input  1  reset; synchronous, active-high.
REQ-006 m{0,1}_addr_i  input  ADDR_WIDTH  cache n bus-side address.
REQ-007 m{0,1}_data_i  input  DATA_WIDTH  cache n write data.
REQ-008 m{0,1}_cyc_i / _stb_i / _sel_i / _we_i  input  1 each  cache n Wishbone cycle, strobe, select and write.
REQ-009 m{0,1}_data_o  output  DATA_WIDTH  read data to cache n.
REQ-010 m{0,1}_ack_o / _err_o / _rty_o  output  1 each  terminations to cache n.
REQ-011 bus_addr_o / bus_data_o  output  ADDR_WIDTH / DATA_WIDTH  shared-bus address and write data.
REQ-012 bus_cyc_o / _stb_o / _sel_o / _we_o  output  1 each  shared-bus control.
REQ-013 bus_data_i  input  DATA_WIDTH  shared-bus read data.
REQ-014 bus_ack_i / _err_i / _rty_i  input  1 each  shared-bus terminations.
REQ-015 grant_o  output  2  one-hot owner: 01 = cache 0, 10 = cache 1, 00 = idle.
REQ-016 timeout_o  output  1  one-cycle pulse when a synthetic error is issued.

Function
REQ-017 The FSM SHALL have three states: IDLE, OWN0 and OWN1; grant_o SHALL decode the state directly.
REQ-018 In IDLE, all bus_* outputs SHALL be 0, and all m*_ack/err/rty/data outputs SHALL be 0.
REQ-019 From IDLE, a request (mn_cyc_i=1) from only one cache SHALL move the FSM to OWNn at the next edge; grant latency SHALL be 1 cycle.
REQ-020 When both caches request in IDLE, the cache not served last (last_r) SHALL win.
REQ-021 last_r SHALL update to n on each entry into OWNn.
REQ-022 In OWNn, the bus_* outputs SHALL equal the mn inputs combinationally, and mn_data_o/ack/err/rty SHALL equal the bus inputs combinationally.
REQ-023 In OWNn, the other cache SHALL see 0 on all of its outputs, and its request SHALL be held pending without loss.
REQ-024 In OWNn, when mn_cyc_i=0, bus_cyc_o SHALL drop in the same cycle; at the next edge the FSM SHALL go to OWN(other) if the other cache is requesting, else to IDLE.
REQ-025 Ownership SHALL NOT change while mn_cyc_i=1; multi-beat and read-modify-write cycles SHALL stay atomic.
REQ-026 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide.
REQ-027 The counter SHALL increment on each OWNn cycle with bus_stb_o=1 and no bus termination.
REQ-028 The counter SHALL clear on any termination, on any state change, and whenever bus_stb_o=0.
REQ-029 When the counter equals TIMEOUT, mn_err_o and timeout_o SHALL assert for exactly one cycle, and the counter SHALL clear.
REQ-030 A bus termination arriving in the timeout cycle SHALL win: it is passed through unchanged, with no synthetic err and no timeout_o.
REQ-031 Bus terminations arriving while in IDLE SHALL be ignored.

Reset
REQ-032 While reset_i=1, bus_cyc_o and bus_stb_o SHALL be forced to 0 combinationally.
REQ-033 At the reset edge, the FSM SHALL go to IDLE, the counter to 0 and last_r to 1 (cache 0 wins the first tie), and timeout_o to 0.
REQ-034 A reset during an owned cycle SHALL abort the cycle without issuing any termination to the cache.

Structure
REQ-035 A shared package nexi_bus_pkg SHALL hold the state encodings (IDLE, OWN0, OWN1) and the grant_o encodings.
REQ-036 The timeout counter SHALL be a sub-module, nexi_bus_timeout, with inputs clk_i, reset_i, count_en, clear and output expired.

Verification
REQ-037 m0 read request alone, bus_ack_i after 3 cycles -> grant_o=01 one cycle after m0_cyc_i rises, m0_ack_o on the ack cycle, m1 outputs 0 throughout.
REQ-038 m0 and m1 request on the same cycle after reset -> grant_o=01 first; on m0 release, grant_o=10 at the next edge with no IDLE cycle.
REQ-039 Repeat the simultaneous request after the m0-then-m1 sequence -> m0 wins again (alternation holds); with m1 holding cyc for 10 beats, grant stays 10 for all 10 beats.
REQ-040 TIMEOUT=4, m1 strobes with no bus response -> m1_err_o and timeout_o high for one cycle on the 5th strobe cycle; counter returns to 0.
REQ-041 TIMEOUT=4, bus_ack_i arrives on the 5th strobe cycle -> m1_ack_o=1, m1_err_o=0, timeout_o=0.
REQ-042 reset_i asserted mid-cycle in OWN0 -> bus_cyc_o=0 immediately, grant_o=00 after the edge, no m0 termination.
